// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: ready/valid byte stream from the receive controller to the
// byte consumer.
//   out_valid  FIFO non-empty (driven by master)
//   out_ready  consumer accepts out_data (driven by slave)
//   out_data   FIFO head word, show-ahead (driven by master)
interface uart_rx_ctrl_if #(
  parameter int unsigned PAYLOAD_BITS = 8
);
  logic                    out_valid;
  logic                    out_ready;
  logic [PAYLOAD_BITS-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller between uart_rx and the byte consumer.
// Gates the receiver enable, buffers words in a show-ahead FIFO, flushes and
// quiesces on BREAK, and reports overrun / break / idle-timeout events.
// Optional feature macro: UART_RX_CTRL_TIMEOUT_EN (idle-timeout counter).
// Ports:
//   clk, resetn        clock, async active-low reset
//   enable, clr        software enable, synchronous FIFO/flag clear
//   rx_valid/_break/_data  word strobe, break flag and payload from uart_rx
//   rx_en              receiver enable back to uart_rx (registered)
//   consumer           ready/valid output stream (uart_rx_ctrl_if.master)
//   level              FIFO occupancy
//   overrun, break_seen  sticky event flags
//   idle_timeout       one-cycle idle-timeout pulse (0 when compiled out)
module uart_rx_ctrl #(
  parameter int unsigned PAYLOAD_BITS   = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned QUIET_CYCLES   = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        clr,
  input  logic                        rx_valid,
  input  logic                        rx_break,
  input  logic [PAYLOAD_BITS-1:0]     rx_data,
  output logic                        rx_en,
  uart_rx_ctrl_if.master              consumer,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overrun,
  output logic                        break_seen,
  output logic                        idle_timeout
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned QCNT_W = $clog2(QUIET_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_BREAK    = 2'd2
  } state_t;

  state_t                  state;
  logic [QCNT_W-1:0]       quiet_cnt;
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;

  logic push_req_c;
  logic push_ok_c;
  logic flush_c;
  logic pop_c;
  logic full_c;

  // Words are only taken while running; a break-flagged word triggers a flush.
  assign push_req_c = (state == ST_RUN) && rx_valid && !rx_break;
  assign flush_c    = (state == ST_RUN) && rx_valid && rx_break;
  assign full_c     = (level == LVL_W'(FIFO_DEPTH));
  assign pop_c      = consumer.out_valid && consumer.out_ready;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok_c  = push_req_c && (!full_c || pop_c);

  assign consumer.out_valid = (level != '0);
  assign consumer.out_data  = mem[rd_ptr];

  // Receive state machine; rx_en is registered alongside the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_DISABLED;
      rx_en     <= 1'b0;
      quiet_cnt <= '0;
    end else begin
      case (state)
        ST_DISABLED: begin
          if (enable) begin
            state <= ST_RUN;
            rx_en <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flush_c) begin
            state     <= ST_BREAK;
            quiet_cnt <= '0;
          end else if (!enable) begin
            state <= ST_DISABLED;
            rx_en <= 1'b0;
          end
        end
        ST_BREAK: begin
          if (!enable) begin
            state     <= ST_DISABLED;
            rx_en     <= 1'b0;
            quiet_cnt <= '0;
          end else if (rx_valid) begin
            quiet_cnt <= '0;
          end else if (quiet_cnt == QCNT_W'(QUIET_CYCLES - 1)) begin
            state     <= ST_RUN;
            quiet_cnt <= '0;
          end else begin
            quiet_cnt <= quiet_cnt + QCNT_W'(1);
          end
        end
        default: begin
          state <= ST_DISABLED;
          rx_en <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage, pointers, occupancy and sticky flags; clr beats flush beats push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overrun    <= 1'b0;
      break_seen <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overrun    <= 1'b0;
      break_seen <= 1'b0;
    end else if (flush_c) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      break_seen <= 1'b1;
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= rx_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok_c && !pop_c)      level <= level + LVL_W'(1);
      else if (pop_c && !push_ok_c) level <= level - LVL_W'(1);
      if (push_req_c && full_c && !pop_c) overrun <= 1'b1;
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TCNT_W-1:0] tmo_cnt;

  // Idle timer: counts buffered-but-unread cycles, pulses once, then holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt      <= '0;
      idle_timeout <= 1'b0;
    end else begin
      idle_timeout <= 1'b0;
      if (clr || flush_c || push_ok_c || (state != ST_RUN)) begin
        tmo_cnt <= '0;
      end else if ((level != '0) && (tmo_cnt != TCNT_W'(TIMEOUT_CYCLES))) begin
        tmo_cnt <= tmo_cnt + TCNT_W'(1);
        if (tmo_cnt == TCNT_W'(TIMEOUT_CYCLES - 1)) idle_timeout <= 1'b1;
      end
    end
  end
`else
  // Feature compiled out; the parameter stays referenced but the result is constant 0.
  assign idle_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed steps plus a randomized phase, every
// cycle compared against a queue-based behavioural model of the controller.
module tb_uart_rx_ctrl;

  localparam int unsigned PB    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned QUIET = 20;
  localparam int unsigned TMO   = 10;

  localparam int M_DIS = 0;
  localparam int M_RUN = 1;
  localparam int M_BRK = 2;

  logic          clk      = 1'b0;
  logic          resetn   = 1'b0;
  logic          enable   = 1'b0;
  logic          clr      = 1'b0;
  logic          rx_valid = 1'b0;
  logic          rx_break = 1'b0;
  logic [PB-1:0] rx_data  = '0;
  logic          rx_en;
  logic [4:0]    level;
  logic          overrun;
  logic          break_seen;
  logic          idle_timeout;

  uart_rx_ctrl_if #(.PAYLOAD_BITS(PB)) bus ();

  uart_rx_ctrl #(
    .PAYLOAD_BITS  (PB),
    .FIFO_DEPTH    (DEPTH),
    .QUIET_CYCLES  (QUIET),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .clr         (clr),
    .rx_valid    (rx_valid),
    .rx_break    (rx_break),
    .rx_data     (rx_data),
    .rx_en       (rx_en),
    .consumer    (bus.master),
    .level       (level),
    .overrun     (overrun),
    .break_seen  (break_seen),
    .idle_timeout(idle_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Reference model: word queue plus mode, quiet run length and flags.
  logic [PB-1:0] q[$];
  int  mode;
  int  quiet;
  int  idle;
  bit  m_ovr;
  bit  m_brk;
  bit  m_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode = M_DIS; quiet = 0; idle = 0;
    m_ovr = 0; m_brk = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit en, input bit c, input bit v, input bit b,
                            input logic [PB-1:0] d, input bit rdy);
    int  pre_mode;
    int  pre_len;
    bit  pop;
    bit  push_req;
    bit  flush;
    bit  accepted;
    pre_mode = mode;
    pre_len  = q.size();
    pop      = (pre_len > 0) && rdy;
    push_req = (pre_mode == M_RUN) && v && !b;
    flush    = (pre_mode == M_RUN) && v && b;
    accepted = 0;
    if (c) begin
      q.delete(); m_ovr = 0; m_brk = 0;
    end else if (flush) begin
      q.delete(); m_brk = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push_req) begin
        if (q.size() < DEPTH) begin
          q.push_back(d); accepted = 1;
        end else m_ovr = 1;
      end
    end
    m_pulse = 0;
    if (c || accepted || flush || pre_mode != M_RUN) idle = 0;
    else if (pre_len > 0 && idle < TMO) begin
      idle++;
      if (idle == TMO) m_pulse = 1;
    end
    case (pre_mode)
      M_DIS: if (en) mode = M_RUN;
      M_RUN: begin
        if (flush) begin mode = M_BRK; quiet = 0; end
        else if (!en) mode = M_DIS;
      end
      default: begin
        if (!en) mode = M_DIS;
        else if (v) quiet = 0;
        else begin
          quiet++;
          if (quiet == QUIET) mode = M_RUN;
        end
      end
    endcase
  endtask

  task automatic check_all();
    check("rx_en", rx_en, (mode != M_DIS));
    check("out_valid", bus.out_valid, (q.size() > 0));
    check("level", level, q.size());
    if (q.size() > 0) check("out_data", bus.out_data, q[0]);
    check("overrun", overrun, m_ovr);
    check("break_seen", break_seen, m_brk);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    check("idle_timeout", idle_timeout, m_pulse);
`else
    check("idle_timeout", idle_timeout, 1'b0);
`endif
  endtask

  task automatic cycle(input bit en, input bit c, input bit v, input bit b,
                       input logic [PB-1:0] d, input bit rdy);
    @(negedge clk);
    enable = en; clr = c; rx_valid = v; rx_break = b; rx_data = d;
    bus.out_ready = rdy;
    model_step(en, c, v, b, d, rdy);
    @(posedge clk);
    #1;
    check_all();
    if (idle_timeout) pulses++;
  endtask

  task automatic idle_cycles(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) cycle(en, 0, 0, 0, '0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    enable = 0; clr = 0; rx_valid = 0; rx_break = 0; rx_data = '0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    model_reset();
    #12;

    // Reset state.
    check("rst_rx_en", rx_en, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_break_seen", break_seen, 1'b0);
    check("rst_idle_timeout", idle_timeout, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Enable and buffer three words without reading.
    cycle(1, 0, 0, 0, '0, 0);
    check("en_rx_en", rx_en, 1'b1);
    cycle(1, 0, 1, 0, 8'h41, 0);
    cycle(1, 0, 1, 0, 8'h42, 0);
    cycle(1, 0, 1, 0, 8'h43, 0);
    check("three_level", level, 5'd3);
    check("three_head", bus.out_data, 8'h41);
    cycle(1, 0, 0, 0, '0, 1);
    cycle(1, 0, 0, 0, '0, 1);
    cycle(1, 0, 0, 0, '0, 1);
    check("three_drained", bus.out_valid, 1'b0);

    // Overflow with 17 words, then clear.
    for (int i = 0; i < 17; i++) cycle(1, 0, 1, 0, PB'($urandom), 0);
    check("ovf_level", level, 5'd16);
    check("ovf_flag", overrun, 1'b1);
    cycle(1, 1, 0, 0, '0, 0);
    check("clr_level", level, 5'd0);
    check("clr_overrun", overrun, 1'b0);

    // Full FIFO with simultaneous push and pop; new word lands at the tail.
    for (int i = 0; i < 16; i++) cycle(1, 0, 1, 0, PB'($urandom), 0);
    cycle(1, 0, 1, 0, 8'hA5, 1);
    check("full_pp_level", level, 5'd16);
    check("full_pp_overrun", overrun, 1'b0);
    idle_cycles(16, 1, 1);
    check("full_pp_empty", bus.out_valid, 1'b0);

    // Break flush, discard during quiet period, quiet-boundary, then resume.
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, PB'($urandom), 0);
    cycle(1, 0, 1, 1, 8'h00, 0);
    check("brk_level", level, 5'd0);
    check("brk_seen", break_seen, 1'b1);
    cycle(1, 0, 1, 0, 8'h55, 0);
    check("brk_discard", level, 5'd0);
    idle_cycles(QUIET - 1, 1, 0);
    cycle(1, 0, 1, 0, 8'h66, 0);
    check("brk_edge_discard", level, 5'd0);
    idle_cycles(QUIET, 1, 0);
    cycle(1, 0, 1, 0, 8'h55, 0);
    check("brk_resume_level", level, 5'd1);
    check("brk_resume_data", bus.out_data, 8'h55);
    cycle(1, 1, 0, 0, '0, 0);

    // Disable with two words buffered; they still drain, new words ignored.
    cycle(1, 0, 1, 0, 8'h10, 0);
    cycle(1, 0, 1, 0, 8'h20, 0);
    cycle(0, 0, 0, 0, '0, 0);
    check("dis_rx_en", rx_en, 1'b0);
    cycle(0, 0, 0, 0, '0, 1);
    cycle(0, 0, 0, 0, '0, 1);
    check("dis_drained", level, 5'd0);
    cycle(0, 0, 1, 0, 8'h77, 0);
    check("dis_ignored", level, 5'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit en, c, v, b, rdy;
      en  = ($urandom % 16) != 0;
      c   = ($urandom % 60) == 0;
      v   = ($urandom % 3) == 0;
      b   = v && (($urandom % 25) == 0);
      rdy = ($urandom % 3) == 0;
      cycle(en, c, v, b, PB'($urandom), rdy);
    end

    // Asynchronous reset in the middle of a BREAK.
    do_reset();
    cycle(1, 0, 0, 0, '0, 0);
    cycle(1, 0, 1, 0, 8'h31, 0);
    cycle(1, 0, 1, 1, 8'h00, 0);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rx_en", rx_en, 1'b0);
    check("async_level", level, 5'd0);
    check("async_break_seen", break_seen, 1'b0);
    check("async_out_data", bus.out_data, 8'h00);
    model_reset();
    enable = 0; rx_valid = 0; rx_break = 0;
    @(negedge clk);
    resetn = 1'b1;

    // Idle timeout: one buffered word, never read.
    cycle(1, 0, 0, 0, '0, 0);
    pulses = 0;
    cycle(1, 0, 1, 0, 8'h99, 0);
    idle_cycles(3 * TMO, 1, 0);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    check("tmo_pulses", pulses, 1);
`else
    check("tmo_pulses", pulses, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
